// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Used by serial_adder_seq and its testbench.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit-counter width; never below one bit so WIDTH=2 still gets a counter.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_seq_if.sv
// Request/result bundle for serial_adder_seq.
// The sub select exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_seq_if #(
    parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout, ovf
    );

endinterface

// File: rtl/serial_adder_seq_fa_cell.sv
// Single full-adder cell; with SERIAL_ADDER_SUB_EN it also serves as a
// full-subtractor, where c_i/cnext_o carry the borrow.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic sub_i,
`endif
    output logic s_o,
    output logic cnext_o
);

    logic a_eff;

    // The borrow equation is the carry majority with operand A inverted.
`ifdef SERIAL_ADDER_SUB_EN
    assign a_eff = a_i ^ sub_i;
`else
    assign a_eff = a_i;
`endif

    assign s_o     = a_i ^ b_i ^ c_i;
    assign cnext_o = (a_eff & b_i) | (a_eff & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial ripple adder: LSB-first, one bit per clock through one fa_cell.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_seq
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_adder_seq_if.slave bus
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;
    logic             busy_q;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_q;
`endif

    logic             s_d;
    logic             c_d;

    fa_cell u_fa (
        .a_i     (a_q[0]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub_q),
`endif
        .b_i     (b_q[0]),
        .c_i     (c_q),
        .s_o     (s_d),
        .cnext_o (c_d)
    );

    // NOTE: every state element, datapath included, sits on the async reset so
    // an abort mid-SHIFT leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register sees the
            // pre-edge values of the others, like real flops.
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        c_q     <= bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q   <= bus.sub;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    sum_q <= {s_d, sum_q[WIDTH-1:1]};
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= c_d;
                    cnt_q <= cnt_q + CW'(1);
                    // c_q is still the carry into the MSB on the last edge.
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= c_d;
                        ovf_q   <= c_q ^ c_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: directed cases plus random
// operands against an arithmetic reference model.
module tb_serial_adder_seq;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    serial_adder_seq_if #(.WIDTH(W)) bus ();

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic cin, input logic sub);
        longint ua, ub, sa, sb, r, sr, span, half;
        logic   co, ov;
        logic [W-1:0] res;
        span = longint'(1) << W;
        half = longint'(1) << (W - 1);
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= half) ? ua - span : ua;
        sb = (ub >= half) ? ub - span : ub;
        if (!sub) begin
            r  = ua + ub + longint'(cin);
            sr = sa + sb + longint'(cin);
            co = (r >= span);
        end else begin
            r  = ua - ub - longint'(cin);
            sr = sa - sb - longint'(cin);
            co = (r < 0);
        end
        ov  = (sr > half - 1) || (sr < -half);
        res = r[W-1:0];
        return {ov, co, res};
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input string tag,
                          output logic [W-1:0] o_sum, output logic o_cout, output logic o_ovf);
        int cyc;
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = sub;
`else
        if (sub) $display("note: %s requests subtract in an add-only build", tag);
`endif
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        check({tag, ".busy"}, 64'(bus.busy), 64'd1);
        wait_done(cyc);
        check({tag, ".latency"}, 64'(cyc), 64'(W));
        o_sum  = bus.sum;
        o_cout = bus.cout;
        o_ovf  = bus.ovf;
        tick();
        check({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [W-1:0] s, ra, rb;
        logic         co, ov, rc, rs;
        logic [W+1:0] exp;
        int           cyc, n_done;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub   = 1'b0;
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.done", 64'(bus.done), 64'd0);
        check("rst.sum",  64'(bus.sum),  64'd0);
        check("rst.cout", 64'(bus.cout), 64'd0);
        check("rst.ovf",  64'(bus.ovf),  64'd0);
        n_done = 0;
        repeat (20) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        check("idle.no_done", 64'(n_done), 64'd0);

        run_op(8'h3C, 8'h25, 1'b0, 1'b0, "add_3c_25", s, co, ov);
        check("add_3c_25.sum", 64'(s), 64'h61);
        check("add_3c_25.cout", 64'(co), 64'd0);
        check("add_3c_25.ovf", 64'(ov), 64'd0);

        run_op(8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01", s, co, ov);
        check("add_ff_01.sum", 64'(s), 64'h00);
        check("add_ff_01.cout", 64'(co), 64'd1);
        check("add_ff_01.ovf", 64'(ov), 64'd0);

        run_op(8'h7F, 8'h01, 1'b1, 1'b0, "add_7f_01_c", s, co, ov);
        check("add_7f_01_c.sum", 64'(s), 64'h81);
        check("add_7f_01_c.cout", 64'(co), 64'd0);
        check("add_7f_01_c.ovf", 64'(ov), 64'd1);

        // Start held high throughout: second pair is captured on the DONE edge.
        bus.a     = 8'd10;
        bus.b     = 8'd20;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.a = 8'd200;
        bus.b = 8'd100;
        wait_done(cyc);
        check("b2b.first_latency", 64'(cyc), 64'(W));
        check("b2b.first_sum", 64'(bus.sum), 64'd30);
        check("b2b.first_cout", 64'(bus.cout), 64'd0);
        tick();
        check("b2b.busy_again", 64'(bus.busy), 64'd1);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 50) begin
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        check("b2b.period", 64'(cyc), 64'(W + 1));
        check("b2b.second_sum", 64'(bus.sum), 64'd44);
        check("b2b.second_cout", 64'(bus.cout), 64'd1);
        tick();
        check("b2b.idle_busy", 64'(bus.busy), 64'd0);
        check("b2b.idle_done", 64'(bus.done), 64'd0);

        // Reset during the 4th SHIFT cycle.
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("midrst.busy_before", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.busy", 64'(bus.busy), 64'd0);
        check("midrst.sum",  64'(bus.sum),  64'd0);
        check("midrst.cout", 64'(bus.cout), 64'd0);
        check("midrst.ovf",  64'(bus.ovf),  64'd0);
        tick();
        rst_n  = 1'b1;
        n_done = 0;
        repeat (15) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) n_done++;
        end
        check("midrst.no_activity", 64'(n_done), 64'd0);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, "sub_05_07", s, co, ov);
        check("sub_05_07.sum", 64'(s), 64'hFE);
        check("sub_05_07.borrow", 64'(co), 64'd1);
        check("sub_05_07.ovf", 64'(ov), 64'd0);

        run_op(8'h80, 8'h01, 1'b0, 1'b1, "sub_80_01", s, co, ov);
        check("sub_80_01.sum", 64'(s), 64'h7F);
        check("sub_80_01.borrow", 64'(co), 64'd0);
        check("sub_80_01.ovf", 64'(ov), 64'd1);
`endif

        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            exp = ref_model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, "rand", s, co, ov);
            check("rand.sum",  64'(s),  64'(exp[W-1:0]));
            check("rand.cout", 64'(co), 64'(exp[W]));
            check("rand.ovf",  64'(ov), 64'(exp[W+1]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
- Bit-serial ripple adder: accepts two WIDTH-bit operands plus carry-in on a start pulse.
- Adds LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- Presents sum, carry-out and signed overflow with a one-cycle done pulse.
- It is the addition counterpart to the existing subtractor cells and the area-minimal add path for Basys3 designs.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, bit counter=0, carry FF=0, operand shift registers=0.
- FSM states and transitions:
  - IDLE: start=1 -> SHIFT; a, b load into shift registers; cin loads into carry FF; counter=0.
  - SHIFT: each edge, one bit is processed:
    - s = a0^b0^c; c' = a0&b0 | a0&c | b0&c.
    - s shifts into the MSB of the sum register (right-shift fill).
    - Operand registers shift right; counter increments.
    - When counter==WIDTH-1 on an edge -> DONE.
    - On that edge: cout=c', ovf=c^c' (c = carry into the MSB bit).
  - DONE: done=1 for exactly this cycle; start=1 -> SHIFT (back-to-back accepted, new operands captured); else -> IDLE.
- Latency: start accepted at edge k; done is high in the cycle following edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- sum is visible in partial form during SHIFT; it is valid only while done=1 and thereafter in IDLE.
- sum, cout and ovf hold their values until the next accepted start.
- start during SHIFT is ignored; it does not queue.
- a, b and cin are don't-care except on the accepting edge.
- Arithmetic is modulo 2^WIDTH; the carry beyond the MSB is reported only on cout.
- Reset asserted mid-SHIFT aborts immediately to reset values; no done pulse is produced.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - sub=1 selects a-b-cin, where cin acts as borrow-in:
    - Per bit: d = a0^b0^bw; bw' = ~a0&b0 | ~a0&bw | b0&bw.
    - cout carries the final borrow-out.
    - ovf = borrow into MSB XOR borrow out of MSB.
  - sub=0 behaves as add.
- Undefined: no sub port; add only.

Decomposition:
- Package serial_adder_pkg holds:
  - state typedef (IDLE, SHIFT, DONE, 2-bit encoding).
  - counter width function/constant clog2(WIDTH).
  - WIDTH default constant.
- One combinational sub-module, fa_cell (a, b, c, sub -> s, cnext), instantiated once. It implements the add equations and, under the macro, the borrow equations.
- FSM, shift registers and carry FF live in the top.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release -> all outputs 0, busy=0, no done pulse for 20 cycles with start=0.
- Basic add, WIDTH=8: a=8'h3C, b=8'h25, cin=0, start one cycle -> busy for 8 cycles, then done=1 for one cycle with sum=8'h61, cout=0, ovf=0.
- Carry/overflow: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0.
- Carry/overflow: a=8'h7F, b=8'h01, cin=1 -> sum=8'h81, cout=0, ovf=1.
- Back-to-back and ignored start: start held high continuously with operand pairs (10,20) then (200,100); start pulses during SHIFT change nothing.
  - done pulses exactly every 9 cycles.
  - Results: first sum=30, cout=0; then sum=44, cout=1.
- Mid-operation reset: assert rst_n=0 at the 4th SHIFT cycle of a=8'hAA, b=8'h55 -> outputs return to 0 asynchronously; after release, no done until a new start.
- With SERIAL_ADDER_SUB_EN: sub=1, a=8'h05, b=8'h07, cin=0 -> sum=8'hFE, cout(borrow)=1, ovf=0.
- With SERIAL_ADDER_SUB_EN: sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, cout=0, ovf=1.
- Randomized check: 500 random operand sets compared against a reference model.
